// File: rtl/mod_counter_pkg.sv
// Shared constants and helpers for mod_counter.
//   DIR_UP / DIR_DN : encodings of the up_dn input
//   params_ok()     : legality check for WIDTH / MAX_VAL, evaluated at elaboration
package mod_counter_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // WIDTH in 2..32, MAX_VAL in 1..2**WIDTH-1. 64-bit math so WIDTH=32 is safe.
  function automatic bit params_ok(input int unsigned width, input longint unsigned max_val);
    bit ok;
    ok = (width >= 2) && (width <= 32);
    if (ok) ok = (max_val >= 64'd1) && (max_val < (64'd1 << width));
    return ok;
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-(MAX_VAL+1) up/down counter with load, wrap pulse and sticky overflow.
//
// Parameters: WIDTH (2..32), MAX_VAL (1..2**WIDTH-1), SATURATE (0 wrap, 1 hold).
// Ports:
//   clk       in   sole clock, rising edge
//   rst       in   synchronous active-high reset
//   en        in   count enable, one step per cycle
//   up_dn     in   1 = increment, 0 = decrement
//   load      in   synchronous load strobe (beats en)
//   load_val  in   [WIDTH] load value, clamped to MAX_VAL
//   clr_ovf   in   clears sticky ovf (a same-cycle boundary event wins)
//   count     out  [WIDTH] registered count
//   tc        out  combinational terminal count for current direction
//   wrap      out  registered one-cycle boundary-event pulse
//   ovf       out  registered sticky boundary-event flag
//
// Build option: define MOD_COUNTER_FORMAL_EN to compile in embedded
// assertions and covers; the default build contains none.
module mod_counter
  import mod_counter_pkg::*;
#(
  parameter int unsigned     WIDTH    = 4,
  parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
  parameter bit              SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  if (!params_ok(WIDTH, MAX_VAL)) begin : g_bad_params
    $error("mod_counter: illegal WIDTH/MAX_VAL combination");
  end

  localparam logic [WIDTH-1:0] MAX_C = MAX_VAL[WIDTH-1:0];

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;
  logic             at_max, at_zero;

  assign at_max  = (count_q == MAX_C);
  assign at_zero = (count_q == '0);

  // Single next-state block: load > en > hold. A boundary event is only an
  // enabled step out of the terminal value, never a load.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    ovf_d   = ovf_q;
    if (load) begin
      count_d = (load_val > MAX_C) ? MAX_C : load_val;
    end else if (en) begin
      if (up_dn == DIR_UP) begin
        if (at_max) begin
          count_d = SATURATE ? MAX_C : '0;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
      end else begin
        if (at_zero) begin
          count_d = SATURATE ? '0 : MAX_C;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
    end
    // Set beats clear so a coincident event is never lost.
    if (wrap_d)       ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;
  assign ovf   = ovf_q;
  assign tc    = (up_dn == DIR_UP) ? at_max : at_zero;

`ifdef MOD_COUNTER_FORMAL_EN
  logic at_bnd;
  assign at_bnd = (up_dn == DIR_UP) ? at_max : at_zero;

  a_range: assert property (@(posedge clk) count_q <= MAX_C);

  a_inc: assert property (@(posedge clk)
    (!rst && !load && en && up_dn == DIR_UP && !at_max) |=> count_q == $past(count_q) + 1'b1);

  a_dec: assert property (@(posedge clk)
    (!rst && !load && en && up_dn == DIR_DN && !at_zero) |=> count_q == $past(count_q) - 1'b1);

  a_wrap_only_bnd: assert property (@(posedge clk)
    !(!rst && !load && en && at_bnd) |=> !wrap_q);

  a_ovf_sticky: assert property (@(posedge clk)
    (ovf_q && !rst && !clr_ovf) |=> ovf_q);

  for (genvar v = 0; v <= int'(MAX_VAL); v++) begin : g_cov_val
    c_val: cover property (@(posedge clk) count_q == WIDTH'(v));
  end

  c_wrap_up: cover property (@(posedge clk) !rst && !load && en && up_dn == DIR_UP && at_max);
  c_wrap_dn: cover property (@(posedge clk) !rst && !load && en && up_dn == DIR_DN && at_zero);
`endif

endmodule
